// File: rtl/messenger_rx_pkg.sv
// Shared constants for the messenger UART receive path: FSM encoding,
// end-of-message character and the ASCII acceptance limit.
package messenger_rx_pkg;

   typedef logic [1:0] rx_state_t;

   localparam rx_state_t StIdle  = 2'd0;
   localparam rx_state_t StStart = 2'd1;
   localparam rx_state_t StData  = 2'd2;
   localparam rx_state_t StStop  = 2'd3;

   localparam logic [7:0] EomChar    = 8'h0D;
   localparam logic [7:0] AsciiLimit = 8'h80;

   localparam int unsigned AddrW = 9;
   localparam int unsigned PtrW  = 10;

   function automatic logic is_ascii(input logic [7:0] b);
      return b < AsciiLimit;
   endfunction

   function automatic logic is_eom(input logic [7:0] b);
      return b == EomChar;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, bit timer and frame FSM.
// Emits a one-cycle byte_valid or frame_err pulse the cycle after the stop sample.
module uart_rx_core
   import messenger_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned TimerW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TimerW-1:0] BitEnd  = TimerW'(CLKS_PER_BIT - 1);
   localparam logic [TimerW-1:0] HalfEnd = TimerW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]        sync_q;
   logic              rx_s;
   rx_state_t         state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        byte_q, byte_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;

   // Both flops preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s = sync_q[1];

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         StIdle: begin
            timer_d = '0;
            if (!rx_s) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (timer_q == HalfEnd) begin
               timer_d   = '0;
               bit_cnt_d = 3'd0;
               state_d   = rx_s ? StIdle : StData;
            end
         end
         StData: begin
            if (timer_q == BitEnd) begin
               timer_d = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (timer_q == BitEnd) begin
               timer_d = '0;
               state_d = StIdle;
               if (rx_s) begin
                  valid_d = 1'b1;
                  byte_d  = shift_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         byte_q    <= 8'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_byte    = byte_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/messenger_rx.sv
// Receives ASCII over UART and writes it sequentially into the document RAM;
// CR ends a message and rewinds the write pointer.
module messenger_rx
   import messenger_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10417,
   parameter int unsigned DOC_DEPTH    = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             RsRx,
   input  logic             clear,
   input  logic             doc_busy,
   output logic             doc_we,
   output logic [AddrW-1:0] doc_a,
   output logic [7:0]       doc_d,
   output logic             done,
   output logic             full,
   output logic             frame_err,
   output logic             overrun
);

   logic [7:0]      core_byte;
   logic            core_valid;
   logic [7:0]      hold_q, hold_d;
   logic            hold_valid_q, hold_valid_d;
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic            overrun_q, overrun_d;
   logic            consume;
   logic            accept;
   logic            occupied;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (RsRx),
      .rx_byte   (core_byte),
      .byte_valid(core_valid),
      .frame_err (frame_err)
   );

   always_comb begin
      full    = (ptr_q == PtrW'(DOC_DEPTH));
      consume = hold_valid_q & ~doc_busy;
      done    = consume & is_eom(hold_q);
      doc_we  = consume & ~is_eom(hold_q) & ~full;
      doc_a   = ptr_q[AddrW-1:0];
      doc_d   = hold_q;
   end

   // A slot being drained this cycle is free for a new byte.
   always_comb begin
      accept       = core_valid & is_ascii(core_byte);
      occupied     = hold_valid_q & ~consume;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q & ~consume;
      overrun_d    = accept & occupied;
      if (accept && !occupied) begin
         hold_d       = core_byte;
         hold_valid_d = 1'b1;
      end
   end

   // clear has priority over the increment of a coincident write.
   always_comb begin
      ptr_d = ptr_q;
      if (clear || done) begin
         ptr_d = '0;
      end else if (doc_we) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q       <= 8'd0;
         hold_valid_q <= 1'b0;
         ptr_q        <= '0;
         overrun_q    <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         ptr_q        <= ptr_d;
         overrun_q    <= overrun_d;
      end
   end

   assign overrun = overrun_q;

endmodule

// File: tb/tb_messenger_rx.sv
// Self-checking bench for messenger_rx: vector table, directed corner cases and
// a randomized run against a queue-based document model.
module tb_messenger_rx;

   localparam int CBP   = 8;
   localparam int DEPTH = 512;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RsRx = 1'b1;
   logic       clear = 1'b0;
   logic       doc_busy = 1'b0;
   logic       doc_we;
   logic [8:0] doc_a;
   logic [7:0] doc_d;
   logic       done;
   logic       full;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   messenger_rx #(
      .CLKS_PER_BIT(CBP),
      .DOC_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RsRx     (RsRx),
      .clear    (clear),
      .doc_busy (doc_busy),
      .doc_we   (doc_we),
      .doc_a    (doc_a),
      .doc_d    (doc_d),
      .done     (done),
      .full     (full),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   int n_we = 0, n_done = 0, n_ferr = 0, n_ovr = 0;
   int got_q[$];

   always @(negedge clk) begin
      if (doc_we) begin
         n_we++;
         got_q.push_back({15'd0, doc_a, doc_d});
      end
      if (done) n_done++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
   end

   int passed = 0, total = 0;
   int b_we, b_done, b_ferr, b_ovr;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic mark();
      b_we = n_we; b_done = n_done; b_ferr = n_ferr; b_ovr = n_ovr;
   endtask

   function automatic int ent(input int a, input int d);
      return (a << 8) | d;
   endfunction

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      RsRx = 1'b0;
      repeat (CBP) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RsRx = b[i];
         repeat (CBP) @(negedge clk);
      end
      RsRx = stop_ok;
      repeat (CBP) @(negedge clk);
      RsRx = 1'b1;
      repeat (CBP) @(negedge clk);
   endtask

   // Control inputs change just after a rising edge so the negedge monitor sees clean pulses.
   task automatic set_ctrl(input logic busy, input logic clr);
      @(posedge clk);
      #1;
      doc_busy = busy;
      clear    = clr;
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         we;
      int         a;
      int         d;
      int         dn;
      int         fe;
   } vec_t;

   vec_t tbl[10];
   int   exp_q[$];
   int   mptr;
   int   lat;
   int   errs;
   logic [7:0] rb;
   bit   rs;

   initial begin
      // Pointer is 1 on entry (latency frame wrote 0x41 at 0).
      tbl[0] = '{8'h0D, 1'b1, 0, 0, 8'h00, 1, 0};
      tbl[1] = '{8'h48, 1'b1, 1, 0, 8'h48, 0, 0};
      tbl[2] = '{8'h49, 1'b1, 1, 1, 8'h49, 0, 0};
      tbl[3] = '{8'h0D, 1'b1, 0, 0, 8'h00, 1, 0};
      tbl[4] = '{8'h41, 1'b1, 1, 0, 8'h41, 0, 0};
      tbl[5] = '{8'h55, 1'b0, 0, 0, 8'h00, 0, 1};
      tbl[6] = '{8'h90, 1'b1, 0, 0, 8'h00, 0, 0};
      tbl[7] = '{8'h7E, 1'b1, 1, 1, 8'h7E, 0, 0};
      tbl[8] = '{8'h0D, 1'b1, 0, 0, 8'h00, 1, 0};
      tbl[9] = '{8'h20, 1'b1, 1, 0, 8'h20, 0, 0};

      repeat (3) @(negedge clk);
      check("rst_doc_we", int'(doc_we), 0);
      check("rst_done", int'(done), 0);
      check("rst_full", int'(full), 0);
      check("rst_doc_a", int'(doc_a), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Start-edge drive to doc_we: 2 sync + 1 detect + half bit + 9 bits + hold stage.
      mark();
      lat = 0;
      fork
         send_frame(8'h41, 1'b1);
         begin
            do begin
               @(negedge clk);
               lat++;
            end while (!doc_we && lat < 300);
         end
      join
      check("latency", lat, 3 + CBP / 2 + 9 * CBP + 1);
      check("lat_we_count", n_we - b_we, 1);
      check("lat_entry", got_q[$], ent(0, 8'h41));

      for (int i = 0; i < 10; i++) begin
         mark();
         send_frame(tbl[i].data, tbl[i].stop_ok);
         check($sformatf("vec%0d_we", i), n_we - b_we, tbl[i].we);
         check($sformatf("vec%0d_done", i), n_done - b_done, tbl[i].dn);
         check($sformatf("vec%0d_ferr", i), n_ferr - b_ferr, tbl[i].fe);
         check($sformatf("vec%0d_ovr", i), n_ovr - b_ovr, 0);
         if (tbl[i].we != 0)
            check($sformatf("vec%0d_entry", i), got_q[$], ent(tbl[i].a, tbl[i].d));
      end

      // Short low glitch must be rejected at the mid-start sample.
      mark();
      RsRx = 1'b0;
      repeat (CBP / 2) @(negedge clk);
      RsRx = 1'b1;
      repeat (12 * CBP) @(negedge clk);
      check("glitch_activity", (n_we - b_we) + (n_done - b_done) + (n_ferr - b_ferr) +
            (n_ovr - b_ovr), 0);

      // Held byte under doc_busy; two later frames overrun. Pointer is 1.
      set_ctrl(1'b1, 1'b0);
      @(negedge clk);
      mark();
      send_frame(8'h31, 1'b1);
      send_frame(8'h32, 1'b1);
      send_frame(8'h33, 1'b1);
      check("busy_overruns", n_ovr - b_ovr, 2);
      check("busy_no_we", n_we - b_we, 0);
      set_ctrl(1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("busy_release_we", n_we - b_we, 1);
      check("busy_release_entry", got_q[$], ent(1, 8'h31));

      // clear coincident with the write: write lands at 2, pointer rewinds.
      set_ctrl(1'b1, 1'b0);
      @(negedge clk);
      send_frame(8'h43, 1'b1);
      mark();
      set_ctrl(1'b0, 1'b1);
      set_ctrl(1'b0, 1'b0);
      @(negedge clk);
      check("clr_coinc_we", n_we - b_we, 1);
      check("clr_coinc_entry", got_q[$], ent(2, 8'h43));
      mark();
      send_frame(8'h44, 1'b1);
      check("clr_after_entry", got_q[$], ent(0, 8'h44));

      // Reset in the middle of an 0xFF frame; pointer was 1.
      RsRx = 1'b0;
      repeat (CBP) @(negedge clk);
      RsRx = 1'b1;
      repeat (3 * CBP) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_doc_a", int'(doc_a), 0);
      check("midrst_doc_d", int'(doc_d), 0);
      check("midrst_outs", int'({doc_we, done, full, frame_err, overrun}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6 * CBP) @(negedge clk);
      mark();
      send_frame(8'h42, 1'b1);
      check("midrst_we", n_we - b_we, 1);
      check("midrst_entry", got_q[$], ent(0, 8'h42));
      check("midrst_ferr", n_ferr - b_ferr, 0);

      // Randomized run against a document model; pointer is 1.
      mptr = 1;
      exp_q.delete();
      mark();
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0:       rb = 8'h0D;
            1:       rb = 8'($urandom_range(128, 255));
            default: rb = 8'($urandom_range(32, 126));
         endcase
         rs = ($urandom_range(0, 9) != 0);
         send_frame(rb, rs);
         if (!rs) begin
         end else if (rb >= 8'h80) begin
         end else if (rb == 8'h0D) begin
            mptr = 0;
         end else if (mptr < DEPTH) begin
            exp_q.push_back(ent(mptr, rb));
            mptr++;
         end
      end
      check("rand_we_count", n_we - b_we, exp_q.size());
      errs = 0;
      for (int i = 0; i < exp_q.size() && (b_we + i) < got_q.size(); i++)
         if (got_q[b_we + i] != exp_q[i]) errs++;
      check("rand_entries_bad", errs, 0);

      // Fill the document to DEPTH from address 0.
      set_ctrl(1'b0, 1'b1);
      set_ctrl(1'b0, 1'b0);
      @(negedge clk);
      check("fill_start_full", int'(full), 0);
      exp_q.delete();
      mark();
      for (int i = 0; i < DEPTH; i++) begin
         rb = 8'($urandom_range(32, 126));
         send_frame(rb, 1'b1);
         exp_q.push_back(ent(i, rb));
      end
      check("fill_we_count", n_we - b_we, DEPTH);
      errs = 0;
      for (int i = 0; i < exp_q.size() && (b_we + i) < got_q.size(); i++)
         if (got_q[b_we + i] != exp_q[i]) errs++;
      check("fill_entries_bad", errs, 0);
      check("fill_full", int'(full), 1);
      mark();
      send_frame(8'h5A, 1'b1);
      check("full_no_we", n_we - b_we, 0);
      check("full_no_done", n_done - b_done, 0);
      set_ctrl(1'b0, 1'b1);
      set_ctrl(1'b0, 1'b0);
      @(negedge clk);
      check("clear_full", int'(full), 0);
      mark();
      send_frame(8'h5A, 1'b1);
      check("after_clear_we", n_we - b_we, 1);
      check("after_clear_entry", got_q[$], ent(0, 8'h5A));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
